// File: rtl/int_ctrl_if.sv
// Signal bundle between the CPU PC logic (master) and the interrupt controller (slave).
interface int_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
);
  logic [NUM_CH-1:0]          irq;
  logic                       step;
  logic                       sti;
  logic                       cli;
  logic                       uret;
  logic [WIDTH-1:0]           pc_next;
  logic [WIDTH-1:0]           pc_target;
  logic                       take;
  logic                       ie;
  logic [NUM_CH-1:0]          pending;
  logic [NUM_CH-1:0]          in_service;
  logic [$clog2(DEPTH+1)-1:0] depth;
  logic                       fault;

  modport master (
    output irq, step, sti, cli, uret, pc_next,
    input  pc_target, take, ie, pending, in_service, depth, fault
  );

  modport slave (
    input  irq, step, sti, cli, uret, pc_next,
    output pc_target, take, ie, pending, in_service, depth, fault
  );
endinterface

// File: rtl/int_ctrl.sv
// Vectored edge-triggered interrupt controller with a return-address/in-service stack.
// Define INT_NEST_EN for a DEPTH-entry stack with priority preemption; otherwise one level, no nesting.
module int_ctrl #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_CH     = 4,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] VEC_BASE   = 'h100,
  parameter int               VEC_STRIDE = 4
) (
  input  logic     clk,
  input  logic     rst,
  int_ctrl_if.slave bus
);
`ifdef INT_NEST_EN
  localparam int SD = DEPTH;
`else
  localparam int SD = 1;
`endif
  localparam int DW  = $clog2(DEPTH + 1);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;

  logic [NUM_CH-1:0] r_irq_q;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_in_service;
  logic [WIDTH-1:0]  r_stk_pc [SD];
  logic [CW-1:0]     r_stk_ch [SD];
  logic [DW-1:0]     r_depth;
  logic              r_ie;
  logic              r_fault;

  logic [SIW-1:0]    w_top;
  logic [SIW-1:0]    w_push;
  logic [CW-1:0]     w_cur;
  logic              w_found;
  logic [CW-1:0]     w_ch;
  logic              w_take;
  logic              w_pop;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_take_oh;
  logic [NUM_CH-1:0] w_pop_oh;
  logic [WIDTH-1:0]  w_vec;

  assign w_top  = (r_depth == '0) ? '0 : SIW'(r_depth - DW'(1));
  assign w_push = SIW'(r_depth);
  assign w_cur  = r_stk_ch[w_top];

  // Scan downward so the lowest-index eligible channel is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
`ifdef INT_NEST_EN
      if (r_pending[c] && ((r_depth == '0) || (CW'(c) < w_cur))) begin
`else
      if (r_pending[c]) begin
`endif
        w_found = 1'b1;
        w_ch    = CW'(c);
      end
    end
  end

  assign w_take    = bus.step & r_ie & w_found & ~bus.uret & (r_depth < DW'(SD));
  assign w_pop     = bus.step & bus.uret & (r_depth != '0);
  assign w_rise    = bus.irq & ~r_irq_q;
  assign w_take_oh = w_take ? (NUM_CH'(1) << w_ch) : '0;
  assign w_pop_oh  = w_pop ? (NUM_CH'(1) << w_cur) : '0;
  assign w_vec     = VEC_BASE + WIDTH'(w_ch) * WIDTH'(VEC_STRIDE);

  assign bus.take       = w_take;
  assign bus.pc_target  = w_take ? w_vec : (w_pop ? r_stk_pc[w_top] : bus.pc_next);
  assign bus.ie         = r_ie;
  assign bus.pending    = r_pending;
  assign bus.in_service = r_in_service;
  assign bus.depth      = r_depth;
  assign bus.fault      = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_q      <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_depth      <= '0;
      r_ie         <= 1'b0;
      r_fault      <= 1'b0;
      for (int i = 0; i < SD; i++) begin
        r_stk_pc[i] <= '0;
        r_stk_ch[i] <= '0;
      end
    end else begin
      r_irq_q      <= bus.irq;
      // A fresh edge in the take cycle re-arms the request immediately.
      r_pending    <= (r_pending & ~w_take_oh) | w_rise;
      r_in_service <= (r_in_service & ~w_pop_oh) | w_take_oh;
      if (bus.step) begin
        if (w_take) begin
          r_stk_pc[w_push] <= bus.pc_next;
          r_stk_ch[w_push] <= w_ch;
          r_depth          <= r_depth + DW'(1);
          r_ie             <= 1'b0;
        end else if (bus.uret) begin
          if (r_depth != '0) begin
            r_depth <= r_depth - DW'(1);
            r_ie    <= 1'b1;
          end else begin
            r_fault <= 1'b1;
          end
        end else if (bus.cli) begin
          r_ie <= 1'b0;
        end else if (bus.sti) begin
          r_ie <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic against a stack/queue model.
module tb_int_ctrl;
  localparam int NCH = 4;
  localparam int DEP = 4;
`ifdef INT_NEST_EN
  localparam int  MD   = DEP;
  localparam bit  NEST = 1'b1;
`else
  localparam int  MD   = 1;
  localparam bit  NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_ctrl_if #(.WIDTH(32), .NUM_CH(NCH), .DEPTH(DEP)) bus ();

  int_ctrl #(
    .WIDTH(32), .NUM_CH(NCH), .DEPTH(DEP), .VEC_BASE(32'h100), .VEC_STRIDE(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: a plain stack of (saved PC, channel) plus pending bits.
  bit [NCH-1:0] m_pend;
  bit [NCH-1:0] m_irq_q;
  bit           m_ie;
  bit           m_fault;
  int           m_stk_ch[$];
  logic [31:0]  m_stk_pc[$];

  logic        obs_take;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_pend = '0; m_irq_q = '0; m_ie = 1'b0; m_fault = 1'b0;
    m_stk_ch.delete(); m_stk_pc.delete();
  endfunction

  function automatic int m_elig();
    for (int c = 0; c < NCH; c++)
      if (m_pend[c] && (!NEST || m_stk_ch.size() == 0 || c < m_stk_ch[$])) return c;
    return -1;
  endfunction

  function automatic bit [NCH-1:0] m_insvc();
    bit [NCH-1:0] v = '0;
    foreach (m_stk_ch[i]) v[m_stk_ch[i]] = 1'b1;
    return v;
  endfunction

  // One clock: drive at negedge, compare everything vs model, advance model for the next posedge.
  task automatic cyc(input logic [NCH-1:0] irq_v, input bit st, input bit si, input bit cl,
                     input bit ur, input logic [31:0] pcn);
    int          e;
    bit          tk;
    logic [31:0] pc_e;
    @(negedge clk);
    bus.irq = irq_v; bus.step = st; bus.sti = si; bus.cli = cl; bus.uret = ur; bus.pc_next = pcn;
    #1;
    e    = m_elig();
    tk   = st && m_ie && (e >= 0) && !ur && (m_stk_ch.size() < MD);
    pc_e = tk ? 32'h100 + 32'(e) * 32'd4 :
           (st && ur && m_stk_ch.size() > 0) ? m_stk_pc[$] : pcn;
    obs_take = bus.take;
    obs_pc   = bus.pc_target;
    chk("take",       64'(bus.take),       64'(tk));
    chk("pc_target",  64'(bus.pc_target),  64'(pc_e));
    chk("pending",    64'(bus.pending),    64'(m_pend));
    chk("in_service", 64'(bus.in_service), 64'(m_insvc()));
    chk("depth",      64'(bus.depth),      64'(m_stk_ch.size()));
    chk("ie",         64'(bus.ie),         64'(m_ie));
    chk("fault",      64'(bus.fault),      64'(m_fault));
    if (tk) m_pend[e] = 1'b0;
    m_pend  = m_pend | (irq_v & ~m_irq_q);
    m_irq_q = irq_v;
    if (st) begin
      if (tk) begin
        m_stk_ch.push_back(e); m_stk_pc.push_back(pcn); m_ie = 1'b0;
      end else if (ur) begin
        if (m_stk_ch.size() > 0) begin
          void'(m_stk_ch.pop_back()); void'(m_stk_pc.pop_back()); m_ie = 1'b1;
        end else m_fault = 1'b1;
      end else if (cl) m_ie = 1'b0;
      else if (si) m_ie = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.irq = '0; bus.step = 0; bus.sti = 0; bus.cli = 0; bus.uret = 0; bus.pc_next = 32'h1234;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_take", 64'(bus.take), 64'd0);
    chk("rst_pc",   64'(bus.pc_target), 64'h1234);
    chk("rst_ie",   64'(bus.ie), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    bus.irq = '0; bus.step = 0; bus.sti = 0; bus.cli = 0; bus.uret = 0; bus.pc_next = '0;
    do_reset();

    // uret on empty stack: no redirect, sticky fault
    cyc(4'b0000, 1, 0, 0, 1, 32'h200);
    chk("fault_pc", 64'(obs_pc), 64'h200);
    cyc(4'b0000, 1, 1, 0, 0, 32'h204);
    chk("fault_sticky", 64'(bus.fault), 64'd1);

    // simultaneous ch1/ch3: ch1 wins, ch3 stays pending
    cyc(4'b1010, 0, 0, 0, 0, 32'h208);
    cyc(4'b1010, 1, 0, 0, 0, 32'h20C);
    chk("ch1_take", 64'(obs_take), 64'd1);
    chk("ch1_vec",  64'(obs_pc), 64'h104);
    cyc(4'b1010, 0, 0, 0, 0, 32'h210);
    chk("ch3_left", 64'(bus.pending), 64'b1000);

    // asynchronous reset inside the handler, no clock edge needed
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_depth", 64'(bus.depth), 64'd0);
    chk("arst_ie",    64'(bus.ie), 64'd0);
    chk("arst_fault", 64'(bus.fault), 64'd0);
    m_reset();
    bus.irq = '0;
    @(negedge clk);
    rst = 1'b0;

    // basic take of ch2 and return
    cyc(4'b0000, 1, 1, 0, 0, 32'h20);
    cyc(4'b0100, 0, 0, 0, 0, 32'h30);
    cyc(4'b0100, 1, 0, 0, 0, 32'h40);
    chk("ch2_take", 64'(obs_take), 64'd1);
    chk("ch2_vec",  64'(obs_pc), 64'h108);
    cyc(4'b0100, 1, 1, 0, 0, 32'h44);
    chk("ch2_depth", 64'(bus.depth), 64'd1);
    chk("ch2_insvc", 64'(bus.in_service), 64'b0100);
    cyc(4'b0101, 1, 0, 0, 0, 32'h48);
    cyc(4'b0101, 1, 0, 0, 0, 32'h4C);
`ifdef INT_NEST_EN
    chk("nest_take", 64'(obs_take), 64'd1);
    chk("nest_vec",  64'(obs_pc), 64'h100);
    cyc(4'b1101, 1, 1, 0, 0, 32'h50);
    cyc(4'b1101, 1, 0, 0, 0, 32'h54);
    chk("ch3_blocked", 64'(obs_take), 64'd0);
    cyc(4'b1101, 1, 0, 0, 1, 32'h58);
    chk("ret_ch0", 64'(obs_pc), 64'h4C);
    cyc(4'b1101, 1, 0, 0, 1, 32'h5C);
    chk("ret_ch2", 64'(obs_pc), 64'h40);
    cyc(4'b1101, 1, 0, 0, 0, 32'h60);
    chk("ch3_vec", 64'(obs_pc), 64'h10C);
`else
    chk("full_no_take", 64'(obs_take), 64'd0);
    chk("full_pend", 64'(bus.pending[0]), 64'd1);
    cyc(4'b0101, 1, 0, 0, 1, 32'h50);
    chk("ret_pc",   64'(obs_pc), 64'h40);
    chk("uret_wins", 64'(obs_take), 64'd0);
    cyc(4'b0101, 1, 0, 0, 0, 32'h54);
    chk("late_take", 64'(obs_pc), 64'h100);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] iv;
      iv = m_irq_q ^ (($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0);
      cyc(iv, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
